// File: rtl/cbb_reg_pipe.sv
// cbb_reg_pipe: DEPTH-stage valid/ready pipeline register built from 2-entry skid slices.
// in_ready, out_valid, out_data and count are all driven directly from flops.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | slice holds nothing (main_v=0, skid_v=0)
// S_ONE   | main register valid, skid free (main_v=1, skid_v=0)
// S_TWO   | main and skid both valid; slice refuses input (main_v=1, skid_v=1)
module cbb_reg_pipe #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 2,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   parameter int               CNT_W    = $clog2(2*DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b10,
      S_TWO   = 2'b11
   } stage_e;

   logic [DEPTH-1:0]       main_v;
   logic [DEPTH-1:0]       skid_v;
   logic [DEPTH*WIDTH-1:0] main_flat;
   logic [CNT_W-1:0]       count_q;
   logic                   in_xfer;
   logic                   out_xfer;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      stage_e           state_q, state_d;
      logic [WIDTH-1:0] main_q, skid_q;
      logic             ld_main, ld_skid, sel_skid;
      logic             up_v, dn_r;
      logic [WIDTH-1:0] up_d;

      if (k == 0) begin : g_first
         assign up_v = in_valid;
         assign up_d = in_data;
      end else begin : g_mid
         assign up_v = main_v[k-1];
         assign up_d = main_flat[(k-1)*WIDTH +: WIDTH];
      end

      if (k == DEPTH-1) begin : g_last
         assign dn_r = out_ready;
      end else begin : g_inner
         assign dn_r = !skid_v[k+1];
      end

      assign main_v[k]                   = (state_q != S_EMPTY);
      assign skid_v[k]                   = (state_q == S_TWO);
      assign main_flat[k*WIDTH +: WIDTH] = main_q;

      always_comb begin
         state_d  = state_q;
         ld_main  = 1'b0;
         ld_skid  = 1'b0;
         sel_skid = 1'b0;
         case (state_q)
            S_EMPTY: begin
               if (up_v) begin
                  ld_main = 1'b1;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               if (up_v && dn_r) begin
                  ld_main = 1'b1;
               end else if (up_v) begin
                  ld_skid = 1'b1;
                  state_d = S_TWO;
               end else if (dn_r) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (dn_r) begin
                  ld_main  = 1'b1;
                  sel_skid = 1'b1;
                  state_d  = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
         // Flush drops every entry but leaves the data registers untouched.
         if (flush) begin
            state_d = S_EMPTY;
            ld_main = 1'b0;
            ld_skid = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= INIT_VAL;
            skid_q  <= INIT_VAL;
         end else begin
            state_q <= state_d;
            if (ld_main) main_q <= sel_skid ? skid_q : up_d;
            if (ld_skid) skid_q <= up_d;
         end
      end
   end

   assign in_ready  = !skid_v[0];
   assign out_valid = main_v[DEPTH-1];
   assign out_data  = main_flat[(DEPTH-1)*WIDTH +: WIDTH];
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign count     = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (flush) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
      end
   end

endmodule

// File: tb/tb_cbb_reg_pipe.sv
// Self-checking bench for cbb_reg_pipe (DEPTH=2, INIT_VAL=0x3C): a stall table,
// hand-written stream/flush/reset sequences and a queue scoreboard on every cycle.
module tb_cbb_reg_pipe;
   localparam int               WIDTH = 8;
   localparam int               DEPTH = 2;
   localparam logic [WIDTH-1:0] INITV = 8'h3C;
   localparam int               CNT_W = $clog2(2*DEPTH+1);

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, out_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_ready, out_valid;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   bit sb_en    = 1'b0;
   logic [WIDTH-1:0] q[$];

   typedef struct {
      logic             iv;
      logic [WIDTH-1:0] id;
      logic             ordy;
      logic             fl;
      logic             e_irdy;
      logic             e_ov;
      logic [WIDTH-1:0] e_od;
      int               e_cnt;
   } vec_t;

   vec_t tbl[12];

   cbb_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_VAL(INITV)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: evaluates the transfers the next rising edge will perform.
   always @(negedge clk) begin
      if (sb_en) begin
         if (!rst) begin
            q.delete();
         end else begin
            chk("sb_count", 32'(count), 32'(q.size()));
            chk("sb_count_max", 32'(count <= CNT_W'(2*DEPTH)), 32'd1);
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  chk("sb_data", 32'(out_data), 32'(q.pop_front()));
               end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) begin
               q.push_back(in_data);
               n_acc++;
            end
         end
      end
   end

   initial begin
      int cyc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'(INITV));
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      sb_en = 1'b1;

      // Full-rate stream with out_ready=1: latency DEPTH, in_ready never drops.
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 8'(i + 1); out_ready = 1'b1;
         @(negedge clk);
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         chk("stream_out_valid", 32'(out_valid), 32'(i >= 2));
         if (i >= 2) chk("stream_out_data", 32'(out_data), 32'(i - 1));
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("stream_drained", 32'(q.size()), 32'd0);

      // Stall to full, toggle in_valid while full, then drain.
      tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
      tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2};
      tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3};
      tbl[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      tbl[5]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      tbl[6]  = '{1'b1, 8'hA6, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 3};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 1};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
      for (int r = 0; r < 12; r++) begin
         in_valid = tbl[r].iv; in_data = tbl[r].id; out_ready = tbl[r].ordy; flush = tbl[r].fl;
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].e_irdy));
         chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
         chk($sformatf("tbl%0d_count", r), 32'(count), 32'(tbl[r].e_cnt));
         if (tbl[r].e_ov) chk($sformatf("tbl%0d_out_data", r), 32'(out_data), 32'(tbl[r].e_od));
         step();
      end

      // Flush with 3 entries stored and a concurrent input (0x55) and output transfer.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(8'hB0 + i);
         step();
      end
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
      @(negedge clk);
      chk("preflush_count", 32'(count), 32'd3);
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_count",     32'(count),     32'd0);
      chk("flush_in_ready",  32'(in_ready),  32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush_no_55", 32'(out_valid), 32'd0);
      end

      // Asynchronous reset in mid-stream, then a fresh stream.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'(8'hC0 + i);
         step();
      end
      #2 rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data",  32'(out_data),  32'(INITV));
      chk("arst_count",     32'(count),     32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 8'(8'hD0 + i);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("post_rst_drained", 32'(q.size()), 32'd0);

      // Random in_valid/out_ready at 50%.
      n_acc = 0;
      cyc = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      chk("rand_budget", 32'(n_acc >= 10000), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 20) begin
         step();
         cyc++;
      end
      @(negedge clk);
      chk("rand_drained", 32'(q.size()), 32'd0);
      chk("rand_count0",  32'(count),    32'd0);

      sb_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cbb_reg_pipe.md
Name: cbb_reg_pipe

Overview:
- Parametrised successor to the plain CBB register: a DEPTH-stage, WIDTH-bit pipeline register with valid/ready handshake.
- Every stage is a 2-entry skid slice, so in_ready and out_valid/out_data all come straight from flops. This breaks timing on both forward and backward paths at full throughput.
- Used between datapath blocks wherever the plain register cannot absorb backpressure. Adds synchronous flush and an occupancy count.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 2, number of skid stages (>=1); also the empty-pipe latency in cycles.
- INIT_VAL, 0, reset value loaded into every main and skid data register.
- CNT_W, $clog2(2*DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all stored entries.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  stage 0 can accept; registered.
- out_valid  output  1  last stage holds data; registered.
- out_data  output  WIDTH  last stage main register; registered.
- out_ready  input  1  downstream accepts.
- count  output  CNT_W  total valid entries in the pipe (0..2*DEPTH); registered.

Behaviour:
- Reset (rst=0, async):
  - all main/skid data registers load INIT_VAL; all main/skid valid bits clear.
  - outputs: out_valid=0, out_data=INIT_VAL, count=0, in_ready=1. in_ready is derived from the cleared skid valid, so it reads 1 during reset.
- Transfers: an input transfer happens when in_valid & in_ready; an output transfer when out_valid & out_ready. Both are evaluated at the rising edge.
- Stage k is fed by stage k-1; stage 0 is fed by the input ports.
  - upstream ready of stage k = !skid_v[k].
  - downstream ready of stage k = ready of stage k+1, or out_ready for the last stage.
- Per-stage FSM, encoded by {main_v, skid_v}:
  - EMPTY (0,0):
    - up_valid -> main<=up_data, go ONE.
    - otherwise stay EMPTY.
  - ONE (1,0):
    - up_valid & dn_ready -> main<=up_data, stay ONE.
    - up_valid & !dn_ready -> skid<=up_data, go TWO.
    - !up_valid & dn_ready -> go EMPTY.
    - neither -> hold.
  - TWO (1,1): up_ready=0.
    - dn_ready -> main<=skid, go ONE.
    - otherwise hold.
- Latency: with an empty pipe and out_ready=1, data accepted at edge N appears on out_data with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH register delays.
- Throughput: one transfer per cycle sustained indefinitely while out_ready=1.
- Ordering: strictly FIFO. No data is dropped or duplicated under any pattern of in_valid/out_ready.
- Data registers load only on an accepted write; they are never cleared except by reset.
- in_ready deasserts only when stage 0 is in TWO. It reasserts the cycle after stage 0 drains its skid.
- Full pipe: 2*DEPTH entries, count=2*DEPTH, in_ready=0.
- Simultaneous input and output transfer: count unchanged.
- count update per edge: count + in_xfer - out_xfer, computed in CNT_W bits. It never wraps, because in_ready already blocks at full.
- flush=1 at an edge:
  - every valid bit clears, count<=0, next cycle in_ready=1, out_valid=0.
  - any input transfer presented in that cycle is discarded.
  - an output transfer in the same cycle still counts as consumed by downstream.
  - data registers keep their values.
- flush and rst together: rst dominates.
- Reset mid-operation: all contents are lost. No partial state survives.
- The downstream port does not depend on out_ready combinationally (out_valid/out_data). The upstream port does not depend on in_valid combinationally (in_ready).

Test Plan:
- Reset, then DEPTH=2, out_ready=1, stream 0x01..0x10 with in_valid=1 -> first out_valid 2 cycles after first accept; outputs 0x01..0x10 in order, one per cycle; in_ready stays 1.
- out_ready=0 while streaming 0xA0.. -> in_ready drops after 4 accepts (0xA0..0xA3) with count=4. Raise out_ready -> 0xA0..0xA3 emerge in order; in_ready returns 1 the cycle after stage 0 drains.
- Random in_valid and out_ready (50%), 10k words, DEPTH=1,2,4 -> scoreboard matches exactly; count always equals accepted minus delivered and never exceeds 2*DEPTH.
- Fill with 3 entries, assert flush together with in_valid=1 (data 0x55) -> next cycle out_valid=0, count=0; 0x55 never appears at the output.
- Assert rst=0 asynchronously mid-stream with INIT_VAL=0x3C -> immediately out_valid=0, out_data=0x3C, count=0, in_ready=1. After release, the pipe accepts a new stream correctly.
- Hold out_ready=0 with pipe full and in_valid toggling -> out_data and count stable; no input accepted.
